// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state type and default parameters for the gated frequency counter
package freq_meter_pkg;

    typedef enum logic [0:0] {
        FM_IDLE = 1'b0,
        FM_GATE = 1'b1
    } fm_state_t;

    localparam int FM_GATE_CYCLES_DEF = 50_000_000;
    localparam int FM_COUNT_W_DEF     = 32;
    localparam int FM_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// rtl/freq_meter_edge_sync.sv - edge_sync: synchronizer chain plus rising-edge detector for an async input
module edge_sync
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = FM_SYNC_STAGES_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the async input through the synchronizer, then keep one cycle of history.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated frequency counter top; FREQ_METER_PERIOD_EN adds the period output
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = FM_GATE_CYCLES_DEF,
    parameter int COUNT_W     = FM_COUNT_W_DEF,
    parameter int SYNC_STAGES = FM_SYNC_STAGES_DEF
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               sig_in,
    input  logic               enable,
    output logic               busy,
    output logic [COUNT_W-1:0] count,
    output logic               valid,
    output logic               overflow
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [COUNT_W-1:0] period
`endif
);

    localparam int                 GW      = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]      GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    fm_state_t          state;
    logic [GW-1:0]      gate_cnt;
    logic [COUNT_W-1:0] edge_cnt;
    logic [COUNT_W-1:0] edge_nxt;
    logic               sticky;
    logic               sticky_nxt;
    logic               rise;
    logic               last;
    logic               abort;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_in(clk_in),
        .rst   (rst),
        .d     (sig_in),
        .rise  (rise)
    );

    assign busy  = (state == FM_GATE);
    assign last  = busy && (gate_cnt == GATE_LAST);
    assign abort = busy && !enable && !last;

    // Saturating edge count including this cycle's pulse; a pulse at full scale marks overflow.
    always_comb begin
        edge_nxt   = edge_cnt;
        sticky_nxt = sticky;
        if (rise) begin
            if (edge_cnt == CNT_MAX) begin
                sticky_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + COUNT_W'(1);
            end
        end
    end

    // Gate FSM, window counters and result registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= FM_IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sticky   <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == FM_IDLE || abort) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sticky   <= 1'b0;
                state    <= (state == FM_IDLE && enable) ? FM_GATE : FM_IDLE;
            end else if (last) begin
                count    <= edge_nxt;
                overflow <= sticky_nxt;
                valid    <= 1'b1;
                gate_cnt <= '0;
                edge_cnt <= '0;
                sticky   <= 1'b0;
                state    <= enable ? FM_GATE : FM_IDLE;
            end else begin
                gate_cnt <= gate_cnt + GW'(1);
                edge_cnt <= edge_nxt;
                sticky   <= sticky_nxt;
            end
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [COUNT_W-1:0] since_cnt;
    logic [COUNT_W-1:0] per_acc;
    logic [COUNT_W-1:0] per_nxt;
    logic               seen_one;
    logic               seen_two;
    logic               two_nxt;

    // Spacing of the newest edge pair, folding in this cycle's pulse.
    always_comb begin
        per_nxt = per_acc;
        two_nxt = seen_two;
        if (rise && seen_one) begin
            per_nxt = since_cnt;
            two_nxt = 1'b1;
        end
    end

    // Track cycles since the previous pulse inside the window; publish with the result.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            since_cnt <= '0;
            per_acc   <= '0;
            seen_one  <= 1'b0;
            seen_two  <= 1'b0;
            period    <= '0;
        end else if (busy && !abort && !last) begin
            since_cnt <= rise ? COUNT_W'(1)
                       : (since_cnt == CNT_MAX) ? since_cnt : since_cnt + COUNT_W'(1);
            seen_one  <= seen_one | rise;
            seen_two  <= two_nxt;
            per_acc   <= per_nxt;
        end else begin
            if (last) begin
                period <= two_nxt ? per_nxt : '0;
            end
            since_cnt <= '0;
            per_acc   <= '0;
            seen_one  <= 1'b0;
            seen_two  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter (GATE_CYCLES=100, COUNT_W=4)
module tb_freq_meter;

    localparam int GC = 100;
    localparam int CW = 4;

    logic          clk_in;
    logic          rst;
    logic          sig_in;
    logic          enable;
    logic          busy;
    logic [CW-1:0] count;
    logic          valid;
    logic          overflow;
`ifdef FREQ_METER_PERIOD_EN
    logic [CW-1:0] period;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int sig_period = 0;
    logic sig_hold = 1'b0;
    int ph = 0;
    int rise_q[$];

    freq_meter #(
        .GATE_CYCLES(GC),
        .COUNT_W    (CW),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .sig_in  (sig_in),
        .enable  (enable),
        .busy    (busy),
        .count   (count),
        .valid   (valid),
        .overflow(overflow)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period  (period)
`endif
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        forever begin
            @(posedge clk_in);
            cyc = cyc + 1;
        end
    end

    // Square-wave source; each rise is logged with the clock edge at which its pulse is counted.
    initial begin
        logic nxt;
        sig_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (sig_period > 0) begin
                ph  = (ph + 1) % sig_period;
                nxt = (ph < sig_period / 2);
            end else begin
                nxt = sig_hold;
            end
            if (nxt && !sig_in) rise_q.push_back(cyc + 3);
            sig_in = nxt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp)
        else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int p);
        logic found;
        found = 1'b0;
        p = 0;
        for (int i = 0; i < 3 * GC && !found; i++) begin
            @(negedge clk_in);
            if (valid === 1'b1) begin
                found = 1'b1;
                p = cyc;
            end
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    function automatic int model_count(input int p);
        int n;
        n = 0;
        foreach (rise_q[i]) if (rise_q[i] >= p - GC + 1 && rise_q[i] <= p) n++;
        return n;
    endfunction

    initial begin
        int p1;
        int p2;
        int nv;
        rst      = 1'b1;
        enable   = 1'b0;
        sig_hold = 1'b1;
        idle_cycles(3);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
`ifdef FREQ_METER_PERIOD_EN
        chk("rst_period", 32'(period), 0);
`endif
        rst = 1'b0;

        // Input high since reset: spurious edge falls in IDLE and must not be counted.
        idle_cycles(20);
        enable = 1'b1;
        idle_cycles(1);
        chk("const1_busy_on", 32'(busy), 1);
        wait_valid("const1_valid_seen", p1);
        chk("const1_count", 32'(count), 0);
        chk("const1_overflow", 32'(overflow), 0);
`ifdef FREQ_METER_PERIOD_EN
        chk("const1_period", 32'(period), 0);
`endif
        enable = 1'b0;
        idle_cycles(2);
        chk("const1_busy_off", 32'(busy), 0);

        // Period 10, back-to-back windows.
        sig_period = 10;
        idle_cycles(10);
        enable = 1'b1;
        wait_valid("p10_valid1_seen", p1);
        chk("p10_count1", 32'(count), 10);
        chk("p10_overflow1", 32'(overflow), 0);
        wait_valid("p10_valid2_seen", p2);
        chk("p10_count2", 32'(count), 10);
        chk("p10_gap", 32'(p2 - p1), GC);
`ifdef FREQ_METER_PERIOD_EN
        chk("p10_period", 32'(period), 10);
`endif
        enable = 1'b0;
        idle_cycles(3);

        // Period 4: 25 edges saturate a 4-bit count.
        sig_period = 4;
        idle_cycles(10);
        enable = 1'b1;
        wait_valid("p4_valid_seen", p1);
        chk("p4_count", 32'(count), 15);
        chk("p4_overflow", 32'(overflow), 1);
        enable = 1'b0;
        idle_cycles(1);
        chk("p4_abort_busy", 32'(busy), 0);
        idle_cycles(5);
        chk("p4_hold_count", 32'(count), 15);
        chk("p4_hold_overflow", 32'(overflow), 1);

        // Period 20: overflow clears with the next result.
        sig_period = 20;
        idle_cycles(10);
        enable = 1'b1;
        wait_valid("p20_valid_seen", p1);
        chk("p20_count", 32'(count), 5);
        chk("p20_overflow", 32'(overflow), 0);
        enable = 1'b0;
        idle_cycles(3);

        // Abort halfway through the second window.
        sig_period = 10;
        idle_cycles(10);
        enable = 1'b1;
        wait_valid("abort_valid1_seen", p1);
        chk("abort_count1", 32'(count), 10);
        idle_cycles(50);
        enable = 1'b0;
        idle_cycles(1);
        chk("abort_busy", 32'(busy), 0);
        nv = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_in);
            if (valid === 1'b1) nv++;
        end
        chk("abort_no_valid", 32'(nv), 0);
        chk("abort_count_hold", 32'(count), 10);

        // Asynchronous reset mid-window, between clock edges.
        sig_period = 4;
        enable = 1'b1;
        wait_valid("rst_mid_prev_seen", p1);
        idle_cycles(30);
        chk("rst_mid_busy_before", 32'(busy), 1);
        @(posedge clk_in);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_valid", 32'(valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_overflow", 32'(overflow), 0);
        enable = 1'b0;
        sig_period = 10;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(10);
        enable = 1'b1;
        wait_valid("rst_restart_seen", p1);
        chk("rst_restart_count", 32'(count), 10);
        chk("rst_restart_overflow", 32'(overflow), 0);
        enable = 1'b0;
        idle_cycles(3);

        // Period 7: count depends on phase; compare with the edge log.
        sig_period = 7;
        idle_cycles(10);
        enable = 1'b1;
        wait_valid("p7_valid_seen", p1);
        chk("p7_count_model", 32'(count), 32'(model_count(p1)));
        chk("p7_count_range", {31'd0, (count == 4'd14 || count == 4'd15)}, 1);
        chk("p7_overflow", 32'(overflow), 0);
`ifdef FREQ_METER_PERIOD_EN
        chk("p7_period", 32'(period), 7);
`endif
        enable = 1'b0;
        idle_cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency counter: the measuring counterpart of the team's clock divider. It samples an asynchronous, slow, square-wave input (a divided clock, a board pin, a test signal), counts its rising edges over a fixed window of `GATE_CYCLES` fast-clock cycles, and reports the count with a one-cycle valid strobe. It sits beside the single-cycle core's clocking logic as a self-check and debug instrument. It also drives seven-segment or LED readouts.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk_in` cycles (1 s at 50 MHz); must be ≥ 2.
- `COUNT_W`, default 32: width of edge count and result.
- `SYNC_STAGES`, default 2: synchronizer depth on `sig_in`; must be ≥ 2.
- `clk_in` input 1: fast FPGA clock; only clock in the block.
- `rst` input 1: asynchronous, active-high reset.
- `sig_in` input 1: asynchronous signal under measurement.
- `enable` input 1: level; high runs back-to-back measurements, low aborts and idles.
- `busy` output 1: high while a gate window is open.
- `count` output COUNT_W: rising edges seen in the last completed window; held between results.
- `valid` output 1: one-cycle pulse when `count` updates.
- `overflow` output 1: set with a result whose edge count saturated; held with `count`.

## Operation
- Front end: `sig_in` → `SYNC_STAGES` flops → previous-value flop. A rising edge is `sync & ~prev`, giving one pulse per input rising edge.
- FSM states:
  - IDLE: `busy`=0; edges ignored; gate counter and edge counter cleared. `enable`=1 → GATE next cycle.
  - GATE: `busy`=1; gate counter runs 0..GATE_CYCLES-1; edge counter increments on each edge pulse.
  - LAST: not a separate state. It is the GATE cycle with gate counter == GATE_CYCLES-1.
- On the last gate cycle, the FSM acts as follows:
  - It registers `result` = edge_cnt + (edge pulse this cycle), saturating.
  - `valid` is asserted next cycle.
  - Both counters reset to 0.
  - If `enable`=1, the FSM stays in GATE with no dead cycle between windows; otherwise it goes to IDLE.
- Edge counter saturates at 2^COUNT_W−1. Further edges set an internal sticky flag, which is copied to `overflow` with the result and then cleared.
- `enable` falling before the last gate cycle aborts the window: no `valid`, `count`/`overflow` keep their previous values, and the FSM enters IDLE next cycle.
- When `enable` falls on the last gate cycle itself, the result is still delivered.
- Edges arriving while in IDLE are never counted, including the spurious edge after reset release when `sig_in` is high.

## Timing
- Reset values: `count`=0, `valid`=0, `busy`=0, `overflow`=0, FSM=IDLE, all synchronizer/counter flops 0.
- Input latency: a `sig_in` rise reaches the edge pulse SYNC_STAGES+1 cycles later (3 at default). Edges in flight at a window boundary fall into the window in which their pulse occurs.
- `enable` 0→1 at edge N gives `busy`=1 from edge N+1. The window covers cycles N+1 .. N+GATE_CYCLES, and `valid` pulses at N+GATE_CYCLES+1.
- Continuous mode: `valid` every GATE_CYCLES cycles exactly.
- Max measurable input rate is `clk_in`/2. Faster inputs alias, and no error is flagged.

## Configuration
- `FREQ_METER_PERIOD_EN` defined: adds output `period` [COUNT_W-1:0]. It holds the `clk_in` cycles between the last two edge pulses within the most recent window, or 0 if there were fewer than 2 edges. It updates with `valid` and is 0 at reset; its counter saturates.
- Undefined: no `period` port and no period logic; the behaviour of all other outputs is identical.

## Structure
- `freq_meter_pkg` holds:
  - `typedef enum logic [0:0] {FM_IDLE, FM_GATE} fm_state_t`
  - default constants `FM_GATE_CYCLES_DEF`, `FM_COUNT_W_DEF`, `FM_SYNC_STAGES_DEF`.
- Sub-module `edge_sync` holds the synchronizer chain plus rising-edge detector, parameterised by `SYNC_STAGES`, with ports `clk_in`, `rst`, `d`, `rise`.
- The top level holds the FSM, counters, result registers and the optional period logic.

## Test plan
- GATE_CYCLES=100, `sig_in` period 10 cycles, `enable` held → `valid` every 100 cycles, `count`=10, `overflow`=0; second window also 10 (no dead time).
- `sig_in` constant 1 from reset, `enable` raised 20 cycles later, GATE_CYCLES=100 → `count`=0.
- COUNT_W=4, GATE_CYCLES=100, `sig_in` period 4 → `count`=15, `overflow`=1; next window at period 20 → `count`=5, `overflow`=0.
- `enable` dropped at gate cycle 50 of the second window → no second `valid`, `count` holds first result, `busy`=0 one cycle later.
- `rst` pulsed mid-window (asynchronous, between clock edges) → `count`/`valid`/`busy`/`overflow` 0 immediately; measurement restarts cleanly after release.
- With `FREQ_METER_PERIOD_EN`, `sig_in` period 7, GATE_CYCLES=100 → `period`=7, `count`=14 or 15 depending on phase, checked against a reference model.
